// File: rtl/booth_feeder_if.sv
// booth_feeder_if: operand, multiplier and product handshake bundle for booth_feeder.
interface booth_feeder_if #(parameter int DEPTH = 4);
    logic                   in_valid;
    logic                   in_ready;
    logic [5:0]             in_x;
    logic [5:0]             in_y;
    logic                   mul_start;
    logic [5:0]             mul_x;
    logic [6:0]             mul_y;
    logic                   mul_ready;
    logic [11:0]            mul_p;
    logic                   out_valid;
    logic [11:0]            out_p;
    logic                   out_ready;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;
    modport slave (
        input  in_valid, in_x, in_y, mul_ready, mul_p, out_ready,
        output in_ready, mul_start, mul_x, mul_y, out_valid, out_p, busy, level
    );
    modport master (
        output in_valid, in_x, in_y, mul_ready, mul_p, out_ready,
        input  in_ready, mul_start, mul_x, mul_y, out_valid, out_p, busy, level
    );
endinterface

// File: rtl/booth_feeder.sv
// booth_feeder: operand FIFO feeding a Booth multiplier one pair at a time,
// holding each product until downstream takes it.
module booth_feeder #(parameter int DEPTH = 4) (
    input logic           clk,
    input logic           rst_n,
    booth_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
    state_t        state_q;
    logic [11:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          mul_start_q, out_valid_q;
    logic [5:0]    mul_x_q;
    logic [6:0]    mul_y_q;
    logic [11:0]   out_p_q, head;
    logic          push, pop, launch;
    assign bus.in_ready  = level_q != LW'(DEPTH);
    assign bus.busy      = state_q != IDLE;
    assign bus.level     = level_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_x     = mul_x_q;
    assign bus.mul_y     = mul_y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign push   = bus.in_valid && bus.in_ready;
    assign pop    = state_q == LAUNCH;
    assign head   = mem_q[rd_ptr_q];
    // Launch only when the output slot will be free by capture time.
    assign launch = state_q == IDLE && level_q != '0 && bus.mul_ready && (!out_valid_q || bus.out_ready);
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.in_x, bus.in_y};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mul_start_q <= 1'b0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else begin
            mul_start_q <= 1'b0;
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (launch) begin
                    state_q     <= LAUNCH;
                    mul_start_q <= 1'b1;
                    mul_x_q     <= head[11:6];
                    mul_y_q     <= {head[5:0], 1'b0};
                end
                LAUNCH:    state_q <= WAIT_BUSY;
                WAIT_BUSY: if (!bus.mul_ready) state_q <= WAIT_DONE;
                default: if (bus.mul_ready) begin
                    state_q     <= IDLE;
                    out_p_q     <= bus.mul_p;
                    out_valid_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/booth_feeder.md
BOOTH_FEEDER -- requirements
Module: booth_feeder

Interface
REQ-001 Parameter DEPTH, default 4, number of operand-FIFO entries (power of two, >=2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream operand pair present.
REQ-005 in_x  input  6  multiplicand, two's complement.
REQ-006 in_y  input  6  multiplier, two's complement.
REQ-007 in_ready  output  1  FIFO can accept a pair (not full).
REQ-008 mul_start  output  1  one-cycle start pulse to the Booth multiplier.
REQ-009 mul_x  output  6  multiplicand to the multiplier.
REQ-010 mul_y  output  7  {multiplier, 1'b0}: Booth operand with appended zero LSB.
REQ-011 mul_ready  input  1  multiplier idle/done flag.
REQ-012 mul_p  input  12  multiplier product, valid when mul_ready returns high.
REQ-013 out_valid  output  1  out_p holds an unconsumed product.
REQ-014 out_p  output  12  captured signed product.
REQ-015 out_ready  input  1  downstream accepts out_p.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 Push occurs when in_valid && in_ready; pair written at wr_ptr, wr_ptr wraps DEPTH-1 -> 0.
REQ-019 in_ready SHALL equal (level != DEPTH), from registered level; push with in_ready low is ignored, even when a pop occurs in the same cycle.
REQ-020 Simultaneous push and pop leaves level unchanged; pop on empty never occurs.
REQ-021 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-022 IDLE -> LAUNCH when level != 0 && mul_ready && (!out_valid || out_ready); otherwise stay.
REQ-023 LAUNCH (one cycle): pop FIFO head into mul_x/mul_y registers, assert mul_start for exactly this cycle, go to WAIT_BUSY.
REQ-024 mul_x/mul_y SHALL remain stable from the cycle after LAUNCH until return to IDLE.
REQ-025 WAIT_BUSY -> WAIT_DONE when mul_ready == 0; else stay.
REQ-026 WAIT_DONE: when mul_ready == 1, capture mul_p into out_p, set out_valid, go to IDLE.
REQ-027 out_valid clears on out_valid && out_ready unless a capture happens in the same cycle (capture wins, out_valid stays 1).
REQ-028 Launch condition of REQ-022 guarantees the output slot is free at capture; no product is ever dropped or overwritten unread.
REQ-029 Back-to-back operation: next LAUNCH may occur in the cycle after capture when REQ-022 holds.
REQ-030 out_p is the product unmodified; no sign or width adjustment applied.
REQ-031 FIFO read data ordering is strict first-in first-out.

Reset
REQ-032 rst low asynchronously forces: state IDLE, pointers 0, level 0, out_valid 0, out_p 0, mul_start 0, mul_x 0, mul_y 0; in_ready 1, busy 0.
REQ-033 Reset asserted mid-multiplication discards the in-flight pair and all FIFO contents; no output produced for them.
REQ-034 Outputs are glitch-free registered values except in_ready and busy (decoded from registers).

Verification
REQ-035 Push (5,3) with model multiplier -> one mul_start pulse, mul_x=6'h05, mul_y=7'h06, then out_valid=1, out_p=12'h00F.
REQ-036 Push (-3,7) -> mul_x=6'h3D, mul_y=7'h0E, out_p=12'hFEB; push (-32,-32) -> out_p=12'h400.
REQ-037 Push 4 pairs with mul_ready held low -> level=4, in_ready=0, 5th push ignored; release -> 4 products in push order.
REQ-038 Hold out_ready=0 after first product -> no second mul_start until out_ready pulses; out_p unchanged meanwhile.
REQ-039 Assert rst during WAIT_DONE with 2 pairs queued -> all REQ-032 values next observation, no out_valid after release.
REQ-040 Push and launch-pop in same cycle at level=2 -> level stays 2, order preserved.
